// File: rtl/seg_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : seg_add_pkg
//  Purpose : Shared types and helpers for the segmented wide adder.
//            - FSM state encoding (IDLE / RUN / DONE)
//            - f_nseg  : number of slices needed to cover WIDTH
//            - f_seg_w : width of the slice counter, never below 1 bit
//  Revision: 1.0  initial release
// ============================================================================
package seg_add_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // A non-positive slice returns 1 so that elaboration reaches the
   // explicit parameter check instead of a divide-by-zero.
   function automatic int f_nseg(input int width, input int slice);
      return (slice > 0) ? (width / slice) : 1;
   endfunction

   // A single-slice configuration still needs a 1-bit counter.
   function automatic int f_seg_w(input int nseg);
      return (nseg > 1) ? $clog2(nseg) : 1;
   endfunction

endpackage : seg_add_pkg
`default_nettype wire

// File: rtl/seg_add_rca.sv
`default_nettype none
// ============================================================================
//  Module  : seg_add_rca
//  Purpose : Parametric ripple-carry adder, purely combinational.
//  Ports   : i_a, i_b  [SIZE-1:0]  addends
//            i_cin                 carry into bit 0
//            o_sum     [SIZE-1:0]  sum
//            o_cout                carry out of bit SIZE-1
//  Revision: 1.0  initial release
// ============================================================================
module seg_add_rca #(
   parameter int SIZE = 16
) (
   input  logic [SIZE-1:0] i_a,
   input  logic [SIZE-1:0] i_b,
   input  logic            i_cin,
   output logic [SIZE-1:0] o_sum,
   output logic            o_cout
);

   logic [SIZE:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar i = 0; i < SIZE; i++) begin : g_bit
      assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
   end

   assign o_cout = w_c[SIZE];

endmodule : seg_add_rca
`default_nettype wire

// File: rtl/seg_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : seg_add_sequencer
//  Purpose : Adds two WIDTH-bit operands over NSEG = WIDTH/SLICE cycles by
//            reusing one SLICE-bit ripple-carry adder and registering the
//            carry between slices. Valid/ready handshake on both sides.
//  Ports   : clk, rst_n (async, active-low)
//            i_in_valid / o_in_ready        operand handshake
//            i_a, i_b [WIDTH-1:0], i_cin    operands and carry-in
//            o_out_valid / i_out_ready      result handshake
//            o_sum [WIDTH-1:0], o_cout      result (only non-zero in DONE)
//            o_busy                         high in RUN or DONE
//            i_sub (SEG_ADD_SUB_EN only)    1 = compute a - b
//  Config  : define SEG_ADD_SUB_EN to add the i_sub port (subtract mode).
//  Revision: 1.0  initial release
// ============================================================================
module seg_add_sequencer
   import seg_add_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int SLICE = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
`ifdef SEG_ADD_SUB_EN
   input  logic             i_sub,
`endif
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_busy
);

   localparam int NSEG  = f_nseg(WIDTH, SLICE);
   localparam int SEG_W = f_seg_w(NSEG);
   localparam logic [SEG_W-1:0] C_SEG_LAST = SEG_W'(NSEG - 1);

   if (SLICE < 1) begin : g_chk_slice
      $error("seg_add_sequencer: SLICE must be >= 1");
   end
   if ((WIDTH % ((SLICE < 1) ? 1 : SLICE)) != 0) begin : g_chk_width
      $error("seg_add_sequencer: WIDTH must be a multiple of SLICE");
   end

   state_t             r_state;
   state_t             w_state_nxt;
   logic [SEG_W-1:0]   r_seg;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carry;

   logic [SLICE-1:0]   w_a_sl;
   logic [SLICE-1:0]   w_b_sl;
   logic [SLICE-1:0]   w_sl_sum;
   logic               w_sl_cout;
   int                 w_shamt;
   logic [WIDTH-1:0]   w_b_cap;
   logic               w_c_cap;

   // Bit offset of the slice being processed this cycle.
   assign w_shamt = int'(r_seg) * SLICE;
   assign w_a_sl  = SLICE'(r_a >> w_shamt);
   assign w_b_sl  = SLICE'(r_b >> w_shamt);

`ifdef SEG_ADD_SUB_EN
   // Subtraction as a + ~b + 1; final carry of 1 means no borrow.
   assign w_b_cap = i_sub ? ~i_b : i_b;
   assign w_c_cap = i_sub ? 1'b1 : i_cin;
`else
   assign w_b_cap = i_b;
   assign w_c_cap = i_cin;
`endif

   seg_add_rca #(
      .SIZE   (SLICE)
   ) u_rca (
      .i_a    (w_a_sl),
      .i_b    (w_b_sl),
      .i_cin  (r_carry),
      .o_sum  (w_sl_sum),
      .o_cout (w_sl_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (i_in_valid)           w_state_nxt = ST_RUN;
         ST_RUN:  if (r_seg == C_SEG_LAST)  w_state_nxt = ST_DONE;
         ST_DONE: if (i_out_ready)          w_state_nxt = ST_IDLE;
         default:                           w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_in_valid) begin
                  r_a     <= i_a;
                  r_b     <= w_b_cap;
                  r_carry <= w_c_cap;
                  r_seg   <= '0;
                  r_sum   <= '0;
               end
            end
            ST_RUN: begin
               // r_sum is cleared on capture, so OR-ing each slice in place
               // is equivalent to a part-select write.
               r_sum   <= r_sum | (WIDTH'(w_sl_sum) << w_shamt);
               r_carry <= w_sl_cout;
               r_seg   <= (r_seg == C_SEG_LAST) ? '0 : r_seg + SEG_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Outputs are gated by DONE so a partial sum is never visible.
   assign o_in_ready  = (r_state == ST_IDLE);
   assign o_out_valid = (r_state == ST_DONE);
   assign o_busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
   assign o_sum       = (r_state == ST_DONE) ? r_sum   : '0;
   assign o_cout      = (r_state == ST_DONE) ? r_carry : 1'b0;

endmodule : seg_add_sequencer
`default_nettype wire

// File: tb/tb_seg_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_seg_add_sequencer
//  Purpose : Self-checking bench for seg_add_sequencer (WIDTH=64, SLICE=16).
//            Expected results come from plain 65-bit arithmetic.
//  Revision: 1.0  initial release
// ============================================================================
module tb_seg_add_sequencer;

   localparam int WIDTH = 64;
   localparam int SLICE = 16;
   localparam int NSEG  = WIDTH / SLICE;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             i_in_valid;
   logic             o_in_ready;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             i_cin;
`ifdef SEG_ADD_SUB_EN
   logic             i_sub;
`endif
   logic             o_out_valid;
   logic             i_out_ready;
   logic [WIDTH-1:0] o_sum;
   logic             o_cout;
   logic             o_busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   seg_add_sequencer #(
      .WIDTH       (WIDTH),
      .SLICE       (SLICE)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .i_a         (i_a),
      .i_b         (i_b),
      .i_cin       (i_cin),
`ifdef SEG_ADD_SUB_EN
      .i_sub       (i_sub),
`endif
      .o_out_valid (o_out_valid),
      .i_out_ready (i_out_ready),
      .o_sum       (o_sum),
      .o_cout      (o_cout),
      .o_busy      (o_busy)
   );

   // Reference: {cout, sum} of an unsigned WIDTH-bit add (or a - b).
   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic c, input logic s);
      if (s) return {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
      return {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present operands, wait (bounded) for in_ready, then take the acceptance edge.
   task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic c, input logic s, output bit ok);
      i_a = a; i_b = b; i_cin = c;
`ifdef SEG_ADD_SUB_EN
      i_sub = s;
`endif
      i_in_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (o_in_ready) begin ok = 1'b1; break; end
         tick();
      end
      tick();
      i_in_valid = 1'b0;
   endtask

   // Cycles from acceptance edge until out_valid; -1 if the bound expires.
   task automatic wait_done(output int cyc);
      cyc = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (o_out_valid) begin cyc = k; break; end
      end
   endtask

   task automatic ack;
      i_out_ready = 1'b1;
      tick();
      i_out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0;
      i_a = '0; i_b = '0; i_cin = 1'b0;
`ifdef SEG_ADD_SUB_EN
      i_sub = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({o_in_ready, o_out_valid, o_busy, o_cout} !== 4'b1000 || o_sum !== '0) begin
         n_fail++;
         $display("FAIL reset: ready/valid/busy/cout=%b sum=%h, want 1000 sum=0",
                  {o_in_ready, o_out_valid, o_busy, o_cout}, o_sum);
      end
      @(negedge clk) rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic;
      bit ok; int cyc;
      start_op(64'h0000_0001_0000_FFFF, 64'h1, 1'b0, 1'b0, ok);
      wait_done(cyc);
      n_checks++;
      if (!ok || cyc !== NSEG) begin
         n_fail++; $display("FAIL basic_latency: got %0d want %0d", cyc, NSEG);
      end
      n_checks++;
      if ({o_cout, o_sum} !== {1'b0, 64'h0000_0001_0001_0000}) begin
         n_fail++; $display("FAIL basic_sum: got %b_%h want 0_0000000100010000", o_cout, o_sum);
      end
      ack();
      n_checks++;
      if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
         n_fail++; $display("FAIL basic_release: valid=%b ready=%b want 0 1", o_out_valid, o_in_ready);
      end
   endtask

   task automatic test_full_ripple;
      bit ok; int cyc;
      start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, ok);
      wait_done(cyc);
      n_checks++;
      if (!ok || cyc !== NSEG || o_cout !== 1'b1 || o_sum !== '0) begin
         n_fail++;
         $display("FAIL full_ripple: lat=%0d cout=%b sum=%h want %0d 1 0", cyc, o_cout, o_sum, NSEG);
      end
      ack();
   endtask

   task automatic test_backpressure;
      bit ok, stable; int cyc;
      logic [WIDTH:0] exp_r;
      logic [WIDTH-1:0] a, b;
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      exp_r = model(a, b, 1'b1, 1'b0);
      start_op(a, b, 1'b1, 1'b0, ok);
      wait_done(cyc);
      n_checks++;
      if (!ok || cyc < 0 || {o_cout, o_sum} !== exp_r) begin
         n_fail++; $display("FAIL bp_result: got %b_%h want %b_%h", o_cout, o_sum, exp_r[WIDTH], exp_r[WIDTH-1:0]);
      end
      // New operands offered while the result is stalled must be ignored.
      i_in_valid = 1'b1; i_a = 64'h3; i_b = 64'h4; i_cin = 1'b0;
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (o_out_valid !== 1'b1 || o_in_ready !== 1'b0 || {o_cout, o_sum} !== exp_r) stable = 1'b0;
      end
      n_checks++;
      if (!stable) begin
         n_fail++; $display("FAIL bp_hold: valid=%b ready=%b got %b_%h want 1 0 %b_%h",
                            o_out_valid, o_in_ready, o_cout, o_sum, exp_r[WIDTH], exp_r[WIDTH-1:0]);
      end
      ack();
      n_checks++;
      if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0 || o_busy !== 1'b0) begin
         n_fail++; $display("FAIL bp_release: ready=%b valid=%b busy=%b want 1 0 0", o_in_ready, o_out_valid, o_busy);
      end
      i_in_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_run;
      bit ok; int cyc;
      start_op(64'hDEAD_BEEF_0123_4567, 64'h1111_2222_3333_4444, 1'b0, 1'b0, ok);
      tick(); tick();       // seg has advanced to 2
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (o_out_valid !== 1'b0 || o_sum !== '0 || o_busy !== 1'b0 || o_in_ready !== 1'b1 || o_cout !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset: valid=%b busy=%b ready=%b sum=%h want 0 0 1 0",
                            o_out_valid, o_busy, o_in_ready, o_sum);
      end
      @(negedge clk) rst_n = 1'b1;
      tick();
      start_op(64'd3, 64'd4, 1'b0, 1'b0, ok);
      wait_done(cyc);
      n_checks++;
      if (!ok || cyc !== NSEG || o_sum !== 64'd7 || o_cout !== 1'b0) begin
         n_fail++; $display("FAIL post_reset: lat=%0d sum=%h cout=%b want %0d 7 0", cyc, o_sum, o_cout, NSEG);
      end
      ack();
   endtask

   task automatic test_back_to_back;
      logic [WIDTH-1:0] pa [2];
      logic [WIDTH-1:0] pb [2];
      logic [WIDTH:0]   exp_q[$];
      int  t_out[$];
      int  idx = 0;
      bit  acc;
      pa[0] = 64'd1; pb[0] = 64'd2; pa[1] = 64'd5; pb[1] = 64'd6;
      i_out_ready = 1'b1; i_cin = 1'b0;
      i_a = pa[0]; i_b = pb[0]; i_in_valid = 1'b1;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         acc = o_in_ready && i_in_valid;
         tick();
         if (acc) begin
            exp_q.push_back(model(pa[idx], pb[idx], 1'b0, 1'b0));
            idx++;
            if (idx < 2) begin i_a = pa[idx]; i_b = pb[idx]; end
            else i_in_valid = 1'b0;
         end
         if (o_out_valid) begin
            t_out.push_back(cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL b2b_extra: unexpected result %h", o_sum);
            end else if ({o_cout, o_sum} !== exp_q[0]) begin
               n_fail++; $display("FAIL b2b_value: got %h want %h", o_sum, exp_q[0][WIDTH-1:0]);
               void'(exp_q.pop_front());
            end else void'(exp_q.pop_front());
         end
      end
      n_checks++;
      if (t_out.size() != 2 || idx != 2) begin
         n_fail++; $display("FAIL b2b_count: got %0d results want 2", t_out.size());
      end else begin
         n_checks++;
         if (t_out[1] - t_out[0] != NSEG + 2) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", t_out[1] - t_out[0], NSEG + 2);
         end
      end
      i_in_valid = 1'b0; i_out_ready = 1'b0;
      tick();
   endtask

   task automatic test_random;
      bit ok; int cyc;
      logic [WIDTH-1:0] a, b;
      logic c, s;
      logic [WIDTH:0] exp_r;
      for (int n = 0; n < 16; n++) begin
         a = {$urandom, $urandom};
         b = (n % 4 == 0) ? ~a : {$urandom, $urandom};
         c = 1'($urandom_range(0, 1));
`ifdef SEG_ADD_SUB_EN
         s = 1'($urandom_range(0, 1));
`else
         s = 1'b0;
`endif
         exp_r = model(a, b, c, s);
         start_op(a, b, c, s, ok);
         wait_done(cyc);
         n_checks++;
         if (!ok || cyc !== NSEG || {o_cout, o_sum} !== exp_r) begin
            n_fail++; $display("FAIL random[%0d]: lat=%0d got %b_%h want %b_%h", n, cyc,
                               o_cout, o_sum, exp_r[WIDTH], exp_r[WIDTH-1:0]);
         end
         repeat ($urandom_range(0, 3)) tick();
         ack();
      end
   endtask

`ifdef SEG_ADD_SUB_EN
   task automatic test_sub;
      bit ok; int cyc;
      start_op(64'd5, 64'd7, 1'b0, 1'b1, ok);
      wait_done(cyc);
      n_checks++;
      if (!ok || o_sum !== 64'hFFFF_FFFF_FFFF_FFFE || o_cout !== 1'b0) begin
         n_fail++; $display("FAIL sub_borrow: got %b_%h want 0_fffffffffffffffe", o_cout, o_sum);
      end
      ack();
      start_op(64'd7, 64'd5, 1'b0, 1'b1, ok);
      wait_done(cyc);
      n_checks++;
      if (!ok || o_sum !== 64'd2 || o_cout !== 1'b1) begin
         n_fail++; $display("FAIL sub_noborrow: got %b_%h want 1_2", o_cout, o_sum);
      end
      ack();
      i_sub = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_full_ripple();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
`ifdef SEG_ADD_SUB_EN
      test_sub();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_seg_add_sequencer
`default_nettype wire

// File: doc/seg_add_sequencer.md
Name: seg_add_sequencer

Overview:
Multi-cycle wide adder controller. It reuses one SLICE-bit ripple-carry adder across NSEG = WIDTH/SLICE cycles to add two WIDTH-bit operands, registering the inter-slice carry. It sits between the Dadda reduction tree output registers and the product register, as an area-saving alternative to a full-width final-stage adder. It uses a valid/ready handshake on both sides.

Parameters:
WIDTH, 64, operand and sum width in bits
SLICE, 16, bits added per cycle; the slice adder is instantiated with SIZE=SLICE
NSEG, WIDTH/SLICE, derived localparam, not overridable

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands valid
in_ready  out  1  sequencer can accept operands
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in to slice 0
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  WIDTH  registered result
cout  out  1  carry-out of the most significant slice
busy  out  1  high in RUN or DONE

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Elaboration checks:
  - WIDTH % SLICE != 0 -> elaboration error.
  - SLICE < 1 -> elaboration error.
  - NSEG = 1 is legal.
- Reset values: state=IDLE, seg=0, a_r/b_r/sum_r=0, carry_r=0, in_ready=1, out_valid=0, sum=0, cout=0, busy=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready: capture a_r<=a, b_r<=b, carry_r<=cin, seg<=0, clear sum_r, go to RUN.
  - RUN: in_ready=0. Each cycle:
    - slice adder inputs are a_r[seg*SLICE +: SLICE], b_r[same], carry_r;
    - sum_r[seg slice] <= slice sum; carry_r <= slice cout; seg <= seg+1.
    - When seg == NSEG-1, go to DONE and wrap seg to 0.
  - DONE: out_valid=1, sum=sum_r, cout=carry_r, in_ready=0. On out_ready go to IDLE; out_valid drops the next cycle.
- Latency:
  - out_valid rises exactly NSEG cycles after the acceptance edge.
  - Minimum initiation interval is NSEG+2 cycles (no DONE->RUN bypass).
- sum and cout are held stable while out_valid=1 && out_ready=0 (backpressure).
- in_valid during RUN or DONE is ignored. The source holds it; no capture occurs.
- out_ready while not in DONE is ignored.
- Arithmetic: unsigned modulo 2^WIDTH; cout = bit WIDTH of a+b+cin.
- Reset asserted mid-operation aborts immediately, with all outputs at reset values. No partial result is ever presented.
- The seg counter width is max(1, $clog2(NSEG)).

Optional Feature:
Macro SEG_ADD_SUB_EN.
- Defined: adds input port `sub` (1 bit), sampled with the operands.
  - When sub=1, b_r captures ~b and carry_r captures 1; cin is ignored.
  - cout=1 means no borrow.
- Undefined: no sub port; behaviour is pure addition as above.

Decomposition:
- Shared package seg_add_pkg:
  - state encoding constants (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - function computing NSEG;
  - function computing the seg counter width.
- One sub-module instance: the codebase's parametric ripple-carry adder with SIZE=SLICE, used combinationally inside the sequencer.
- No other sub-modules; the FSM, counter and registers stay in seg_add_sequencer.

Test Plan (WIDTH=64, SLICE=16):
- Basic: a=64'h0000_0001_0000_FFFF, b=64'h1, cin=0 -> sum=64'h0000_0001_0001_0000, cout=0; out_valid exactly 4 cycles after acceptance.
- Full ripple: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1; carry propagates across all 4 slices.
- Backpressure: out_ready held 0 for 10 cycles in DONE -> out_valid stays 1, sum/cout unchanged, in_ready=0 and a new in_valid is not captured. out_ready=1 -> IDLE; in_ready=1 the following cycle.
- Reset mid-RUN: assert rst_n=0 asynchronously at seg=2 -> out_valid=0, sum=0, busy=0 immediately. After release, a=3, b=4 completes with sum=7.
- Back-to-back: in_valid held high with operand pairs (1,2), (5,6) and out_ready=1 -> results 3 then 11, spaced NSEG+2=6 cycles apart, none dropped or duplicated.
- With SEG_ADD_SUB_EN: a=5, b=7, sub=1 -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0. Then a=7, b=5, sub=1 -> sum=2, cout=1.
